// File: rtl/clock_set.sv
// Settable hour/minute/second time-of-day counter driven by a single-clock prescaler tick.
// A four-state set-mode FSM selects a field that single-cycle inc pulses advance modulo its own range.
module clock_set #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int HOUR_M    = 24,
  parameter int MIN_M     = 60,
  parameter int SEC_M     = 60,
  parameter int HOUR_INIT = 0,
  parameter int MIN_INIT  = 0,
  parameter int SEC_INIT  = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        mode,
  input  logic        inc,
  output logic [23:0] cur_time,
  output logic [1:0]  field_sel,
  output logic        sec_pulse,
  output logic        day_pulse
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  localparam logic [7:0] HOUR_LAST = 8'(HOUR_M - 1);
  localparam logic [7:0] MIN_LAST  = 8'(MIN_M - 1);
  localparam logic [7:0] SEC_LAST  = 8'(SEC_M - 1);
  localparam logic [7:0] HOUR_RST  = 8'(HOUR_INIT);
  localparam logic [7:0] MIN_RST   = 8'(MIN_INIT);
  localparam logic [7:0] SEC_RST   = 8'(SEC_INIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     hour_q, hour_d;
  logic [7:0]     min_q, min_d;
  logic [7:0]     sec_q, sec_d;
  logic           sec_pulse_q, sec_pulse_d;
  logic           day_pulse_q, day_pulse_d;

  logic run, set_hour, set_min, set_sec;
  logic tick, sec_wrap, min_wrap, hour_wrap, inc_act;

  // Modulo increment of one time field; last is the field's final legal value.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] last);
    return (v == last) ? 8'd0 : v + 8'd1;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: mode cycles RUN -> HOUR -> MIN -> SEC -> RUN
  always_comb begin
    state_d = state_q;
    if (mode) begin
      unique case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_SET_SEC;
        ST_SET_SEC:  state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    run       = (state_q == ST_RUN);
    set_hour  = (state_q == ST_SET_HOUR);
    set_min   = (state_q == ST_SET_MIN);
    set_sec   = (state_q == ST_SET_SEC);
    field_sel = state_q;
  end

  assign tick      = run & en & (presc_q == PRESC_LAST);
  assign sec_wrap  = (sec_q == SEC_LAST);
  assign min_wrap  = (min_q == MIN_LAST);
  assign hour_wrap = (hour_q == HOUR_LAST);
  // mode has priority over a coincident inc
  assign inc_act   = inc & ~mode;

  always_comb begin
    presc_d = presc_q;
    if (run && en)
      presc_d = tick ? '0 : presc_q + 1'b1;
    else if (set_sec && mode)
      presc_d = '0;
  end

  // All carries resolve on the same edge; set-mode increments never carry.
  always_comb begin
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    sec_pulse_d = tick;
    day_pulse_d = tick & sec_wrap & min_wrap & hour_wrap;
    if (tick) begin
      sec_d = wrap_inc(sec_q, SEC_LAST);
      if (sec_wrap) begin
        min_d = wrap_inc(min_q, MIN_LAST);
        if (min_wrap) hour_d = wrap_inc(hour_q, HOUR_LAST);
      end
    end else if (inc_act) begin
      if (set_hour) hour_d = wrap_inc(hour_q, HOUR_LAST);
      if (set_min)  min_d  = wrap_inc(min_q, MIN_LAST);
      if (set_sec)  sec_d  = wrap_inc(sec_q, SEC_LAST);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q     <= '0;
      hour_q      <= HOUR_RST;
      min_q       <= MIN_RST;
      sec_q       <= SEC_RST;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign cur_time  = {hour_q, min_q, sec_q};
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_set.sv
// Bench for clock_set: two instances (standard 24/60/60 and small custom moduli) checked every
// cycle against a seconds-of-day reference model, plus directed scenario checks.
module tb_clock_set;
  localparam int CF = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic en = 1'b0, mode = 1'b0, inc = 1'b0;

  logic [23:0] time_a, time_b;
  logic [1:0]  fs_a, fs_b;
  logic        sp_a, sp_b, dp_a, dp_b;

  clock_set #(.CLK_FREQ(CF), .HOUR_M(24), .MIN_M(60), .SEC_M(60),
              .HOUR_INIT(23), .MIN_INIT(59), .SEC_INIT(58)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .inc(inc),
    .cur_time(time_a), .field_sel(fs_a), .sec_pulse(sp_a), .day_pulse(dp_a));

  clock_set #(.CLK_FREQ(CF), .HOUR_M(5), .MIN_M(3), .SEC_M(21),
              .HOUR_INIT(4), .MIN_INIT(2), .SEC_INIT(20)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .inc(inc),
    .cur_time(time_b), .field_sel(fs_b), .sec_pulse(sp_b), .day_pulse(dp_b));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  int HM[2] = '{24, 5};
  int MM[2] = '{60, 3};
  int SM[2] = '{60, 21};
  int INIT_TOT[2] = '{(23*60+59)*60+58, (4*3+2)*21+20};

  // Model: time as seconds since midnight, prescaler count, mode index 0..3
  int m_tot[2], m_presc[2], m_state[2];
  bit m_sp[2], m_dp[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_time(input int i);
    int h, m, s;
    h = m_tot[i] / (MM[i] * SM[i]);
    m = (m_tot[i] / SM[i]) % MM[i];
    s = m_tot[i] % SM[i];
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tot[i] = INIT_TOT[i];
      m_presc[i] = 0;
      m_state[i] = 0;
      m_sp[i] = 0;
      m_dp[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int h, m, s;
      bit tick;
      m_sp[i] = 0;
      m_dp[i] = 0;
      tick = (m_state[i] == 0) && en && (m_presc[i] == CF - 1);
      if (m_state[i] == 0 && en) begin
        if (tick) begin
          m_presc[i] = 0;
          m_tot[i] = (m_tot[i] + 1) % (HM[i] * MM[i] * SM[i]);
          m_sp[i] = 1;
          m_dp[i] = (m_tot[i] == 0);
        end else begin
          m_presc[i]++;
        end
      end
      if (mode) begin
        if (m_state[i] == 3) m_presc[i] = 0;
        m_state[i] = (m_state[i] + 1) % 4;
      end else if (inc && m_state[i] != 0) begin
        h = m_tot[i] / (MM[i] * SM[i]);
        m = (m_tot[i] / SM[i]) % MM[i];
        s = m_tot[i] % SM[i];
        case (m_state[i])
          1: h = (h + 1) % HM[i];
          2: m = (m + 1) % MM[i];
          default: s = (s + 1) % SM[i];
        endcase
        m_tot[i] = (h * MM[i] + m) * SM[i] + s;
      end
    end
  endtask

  task automatic check_all();
    chk("A.time", 32'(time_a), 32'(exp_time(0)));
    chk("A.fsel", 32'(fs_a), 32'(m_state[0]));
    chk("A.sec_pulse", 32'(sp_a), 32'(m_sp[0]));
    chk("A.day_pulse", 32'(dp_a), 32'(m_dp[0]));
    chk("B.time", 32'(time_b), 32'(exp_time(1)));
    chk("B.fsel", 32'(fs_b), 32'(m_state[1]));
    chk("B.sec_pulse", 32'(sp_b), 32'(m_sp[1]));
    chk("B.day_pulse", 32'(dp_b), 32'(m_dp[1]));
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
    check_all();
    cyc++;
  endtask

  // Called at a falling edge; reset drops between edges and is checked before the next rising edge
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1 model_reset();
    chk("rst.A.time", 32'(time_a), {8'd0, 8'd23, 8'd59, 8'd58});
    chk("rst.A.fsel", 32'(fs_a), 32'd0);
    chk("rst.A.pulses", {30'd0, sp_a, dp_a}, 32'd0);
    chk("rst.B.time", 32'(time_b), {8'd0, 8'd4, 8'd2, 8'd20});
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse_mode(input int n);
    repeat (n) begin
      mode = 1'b1; step();
      mode = 1'b0; step();
    end
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      inc = 1'b1; step();
      inc = 1'b0; step();
    end
  endtask

  initial begin
    logic [23:0] t_before;
    en = 1'b1;
    @(negedge clk);
    async_reset();

    // Reset and count from 23:59:58
    repeat (9) begin
      step();
      if (cyc == 3) chk("cnt.c3.sp", 32'(sp_a), 32'd0);
      if (cyc == 4) begin
        chk("cnt.c4.time", 32'(time_a), {8'd0, 8'd23, 8'd59, 8'd59});
        chk("cnt.c4.sp", 32'(sp_a), 32'd1);
        chk("cust.c4.time", 32'(time_b), 32'd0);
        chk("cust.c4.dp", 32'(dp_b), 32'd1);
      end
      if (cyc == 5) chk("cnt.c5.sp", 32'(sp_a), 32'd0);
      if (cyc == 8) begin
        chk("cnt.c8.time", 32'(time_a), 32'd0);
        chk("cnt.c8.sp_dp", {30'd0, sp_a, dp_a}, 32'd3);
      end
      if (cyc == 9) chk("cnt.c9.dp", 32'(dp_a), 32'd0);
    end

    // Enable low across edges 2..4
    async_reset();
    step();
    en = 1'b0;
    repeat (3) step();
    chk("en.c4.sp", 32'(sp_a), 32'd0);
    chk("en.c4.time", 32'(time_a), {8'd0, 8'd23, 8'd59, 8'd58});
    en = 1'b1;
    repeat (7) begin
      step();
      if (cyc == 7) begin
        chk("en.c7.sp", 32'(sp_a), 32'd1);
        chk("en.c7.time", 32'(time_a), {8'd0, 8'd23, 8'd59, 8'd59});
      end
      if (cyc == 10) chk("en.c10.sp", 32'(sp_a), 32'd0);
      if (cyc == 11) begin
        chk("en.c11.sp", 32'(sp_a), 32'd1);
        chk("en.c11.time", 32'(time_a), 32'd0);
      end
    end

    // Set sequence: bring A to 10:20:30, then exercise wraps
    pulse_mode(1); pulse_inc(10);
    pulse_mode(1); pulse_inc(20);
    pulse_mode(1); pulse_inc(30);
    pulse_mode(1);
    chk("set.run.fsel", 32'(fs_a), 32'd0);
    chk("set.start.time", 32'(time_a), {8'd0, 8'd10, 8'd20, 8'd30});
    pulse_mode(1);
    pulse_inc(15);
    chk("set.hour.fsel", 32'(fs_a), 32'd1);
    chk("set.hour.time", 32'(time_a), {8'd0, 8'd1, 8'd20, 8'd30});
    pulse_mode(1);
    pulse_inc(40);
    chk("set.min.fsel", 32'(fs_a), 32'd2);
    chk("set.min.time", 32'(time_a), {8'd0, 8'd1, 8'd0, 8'd30});
    mode = 1'b1; step();
    chk("set.sec.fsel", 32'(fs_a), 32'd3);
    step();
    mode = 1'b0;
    chk("set.back.fsel", 32'(fs_a), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk("set.hold.sp", {31'd0, sp_a}, 32'd0);
      else begin
        chk("set.first.sp", 32'(sp_a), 32'd1);
        chk("set.first.time", 32'(time_a), {8'd0, 8'd1, 8'd0, 8'd31});
      end
    end

    // Simultaneous mode and inc in RUN
    t_before = exp_time(0);
    mode = 1'b1; inc = 1'b1; step();
    mode = 1'b0; inc = 1'b0;
    chk("sim.fsel", 32'(fs_a), 32'd1);
    chk("sim.time", 32'(time_a), 32'(t_before));
    pulse_mode(3);

    // Async reset while in SET_MIN, then normal counting
    pulse_mode(2);
    pulse_inc(3);
    chk("async.pre.fsel", 32'(fs_a), 32'd2);
    async_reset();
    repeat (4) step();
    chk("async.c4.time", 32'(time_a), {8'd0, 8'd23, 8'd59, 8'd59});
    chk("async.c4.sp", 32'(sp_a), 32'd1);

    // Randomized traffic
    repeat (3000) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 11) == 0);
      inc  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
